watch_bcd_scan: RTL and testbench
=================================

// Module: watch_bcd_scan
// PURPOSE
//  Parametrised BCD timekeeper (HH:MM:SS) with 12/24-hour mode, validated time load,
//  and a multiplexed N-digit 7-seg scan driver. Sits between the 1 Hz prescaler domain
//  and the display7 decoder. Next-generation watch core for the alarm project.
// PARAMETERS
//  TICK_DIV    50_000_000  clk cycles per second tick (>=1; 1 = tick every enabled cycle)
//  SCAN_DIV    50_000      clk cycles per display digit step (>=1)
//  H24         1           1: hours 00-23; 0: hours 01-12 with pm flag
//  NUM_DIGITS  4           4: shows HH:MM; 6: shows HH:MM:SS
// PORTS
//  clk       in   1    system clock
//  rst       in   1    reset, synchronous, active-high
//  run       in   1    1: timekeeping prescaler advances; 0: time frozen
//  load      in   1    load request, sampled every cycle
//  ld_time   in   24   BCD {hd,ho,md,mo,sd,so}, 4 bits per digit
//  ld_pm     in   1    pm flag loaded with ld_time (ignored when H24=1)
//  time_bcd  out  24   current time, same packing as ld_time
//  pm        out  1    1 = PM (always 0 when H24=1)
//  sec_tick  out  1    one-cycle pulse on each second advance
//  ld_err    out  1    one-cycle pulse: load rejected
//  digit     out  4    BCD value of the currently scanned digit, to display7
//  an        out  NUM_DIGITS  digit enables, active-low, one-hot-zero
// BEHAVIOUR
//  Reset: time 00:00:00 (H24=1) / 12:00:00 with pm=0 (H24=0); prescalers 0; scan idx 0;
//   sec_tick=0, ld_err=0, an=all 1s, digit=0. rst overrides everything, incl. mid-load.
//  Prescaler: when run=1, counts 0..TICK_DIV-1; at TICK_DIV-1 wraps to 0 and the time
//   advances one second; sec_tick=1 in the cycle time_bcd shows the new value.
//   run=0 holds the prescaler value (no tick while stopped).
//  Carry chain: so 0-9, sd 0-5, mo 0-9, md 0-5; carries ripple in the same cycle.
//   H24=1: 23:59:59 -> 00:00:00.
//   H24=0: 11:59:59 -> 12:00:00 and pm toggles; 12:59:59 -> 01:00:00, pm unchanged.
//  Load: valid if every digit is in range (so<=9, sd<=5, mo<=9, md<=5), hours 00-23 (H24=1)
//   or 01-12 (H24=0). Valid: time_bcd<=ld_time, pm<=ld_pm (H24=0), prescaler<=0 next cycle.
//   Invalid: time unchanged, ld_err=1 for one cycle. Load has priority over a coincident
//   tick; the tick is dropped and sec_tick stays 0.
//  Scan: free-running (independent of run). SCAN_DIV prescaler; on wrap idx steps
//   0,1,..,NUM_DIGITS-1,0. idx 0 = least-significant shown digit (mo if 4 digits, so if 6).
//  Scan outputs: an <= ~(1<<idx), digit <= time digit[idx], registered every cycle.
//   Latency: 1 clk after idx or time change. Exactly one an bit low after the first cycle.
//  Internal counters are sized $clog2(DIV); no overflow. Output widths are fixed as listed.
// CONFIGURATION
//  WATCH_ALARM_EN defined: adds ports al_set(in,1), al_time(in,16 BCD {hd,ho,md,mo}),
//   al_pm(in,1), alarm(out,1). al_set stores al_time/al_pm if valid (same hour/min rules);
//   invalid -> ignored, ld_err pulse. Reset alarm = 00:00 (H24=1) / 12:00 am (H24=0).
//   alarm=1 for exactly one cycle, coincident with the sec_tick that makes time equal
//   HH:MM:00 == stored alarm (and pm match when H24=0). A load never raises alarm.
//  WATCH_ALARM_EN undefined: no alarm ports or registers; all other behaviour identical.
// TESTING
//  1. TICK_DIV=4, rst 2 cycles then run=1 -> an=all 1s during rst; 4 cycles later sec_tick=1, time 00:00:01.
//  2. H24=1, load 23:59:59, run -> next tick time 00:00:00; load coincident with tick -> loaded value, no sec_tick.
//  3. H24=0, load 11:59:59 pm=0 -> tick gives 12:00:00 pm=1; load 12:59:59 pm=1 -> 01:00:00 pm=1.
//  4. Load 24:00:00 (H24=1) or so=4'hA -> ld_err one-cycle pulse, time_bcd unchanged.
//  5. NUM_DIGITS=6, SCAN_DIV=2, time 12:34:56 -> (an,digit): (111110,6),(111101,5),(111011,4),...,(011111,1), wrap.
//  6. WATCH_ALARM_EN, alarm 07:30, load 07:29:58, run -> alarm pulses once at 07:30:00; rst mid-count -> time/alarm reset values.

Source files
------------

// File: rtl/watch_bcd_scan.sv
// watch_bcd_scan
//   BCD timekeeper (HH:MM:SS) with 12/24-hour mode, validated time load and a
//   multiplexed N-digit seven-segment scan driver. It sits between the 1 Hz
//   prescaler domain and the display7 decoder.
//
//   Optional alarm: define WATCH_ALARM_EN to add the alarm ports and registers.
//   With the macro undefined there are no alarm ports, and everything else is unchanged.
//
// Parameters
//   TICK_DIV    clk cycles per second tick (>=1; 1 = tick on every running cycle)
//   SCAN_DIV    clk cycles per display digit step (>=1)
//   H24         1: hours 00-23; 0: hours 01-12 with pm flag
//   NUM_DIGITS  4: scans HH:MM; 6: scans HH:MM:SS
//
// Ports
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   run       in   1: second prescaler advances; 0: time frozen
//   load      in   load request, sampled every cycle
//   ld_time   in   BCD {hd,ho,md,mo,sd,so}
//   ld_pm     in   pm flag loaded with ld_time (ignored in 24-hour mode)
//   al_set    in   (WATCH_ALARM_EN) store al_time/al_pm as the alarm
//   al_time   in   (WATCH_ALARM_EN) BCD {hd,ho,md,mo}
//   al_pm     in   (WATCH_ALARM_EN) alarm pm flag
//   alarm     out  (WATCH_ALARM_EN) one-cycle pulse when a tick reaches the alarm minute
//   time_bcd  out  current time, same packing as ld_time
//   pm        out  1 = PM (always 0 in 24-hour mode)
//   sec_tick  out  one-cycle pulse in the cycle time_bcd shows the new second
//   ld_err    out  one-cycle pulse when a load (or alarm set) is rejected
//   digit     out  BCD value of the digit currently scanned
//   an        out  active-low digit enables, one-hot-zero
module watch_bcd_scan #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int SCAN_DIV   = 50_000,
  parameter int H24        = 1,
  parameter int NUM_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  load,
  input  logic [23:0]           ld_time,
  input  logic                  ld_pm,
`ifdef WATCH_ALARM_EN
  input  logic                  al_set,
  input  logic [15:0]           al_time,
  input  logic                  al_pm,
  output logic                  alarm,
`endif
  output logic [23:0]           time_bcd,
  output logic                  pm,
  output logic                  sec_tick,
  output logic                  ld_err,
  output logic [3:0]            digit,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic          IS_24     = (H24 != 0);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  // A 4-digit display starts at the minutes-units digit, skipping the seconds.
  localparam logic [2:0]    DIG_OFS   = (NUM_DIGITS == 4) ? 3'd2 : 3'd0;
  localparam logic [23:0]   TIME_RST  = IS_24 ? 24'h000000 : 24'h120000;

  // Hour pair is legal for the selected mode (00-23 or 01-12).
  function automatic logic hour_ok(input logic [3:0] hd, input logic [3:0] ho);
    logic ok;
    if (IS_24) begin
      if (hd < 4'd2) begin
        ok = (ho <= 4'd9);
      end else if (hd == 4'd2) begin
        ok = (ho <= 4'd3);
      end else begin
        ok = 1'b0;
      end
    end else begin
      if (hd == 4'd0) begin
        ok = (ho >= 4'd1) && (ho <= 4'd9);
      end else if (hd == 4'd1) begin
        ok = (ho <= 4'd2);
      end else begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

  // Minute or second pair is legal (tens 0-5, units 0-9).
  function automatic logic sixty_ok(input logic [3:0] tens, input logic [3:0] units);
    return (tens <= 4'd5) && (units <= 4'd9);
  endfunction

  function automatic logic time_ok(input logic [23:0] t);
    return hour_ok(t[23:20], t[19:16]) && sixty_ok(t[15:12], t[11:8]) &&
           sixty_ok(t[7:4], t[3:0]);
  endfunction

  // One-second advance with full BCD ripple; returns {pm, time}.
  function automatic logic [24:0] advance(input logic [23:0] t, input logic p);
    logic [3:0] hd, ho, md, mo, sd, so;
    logic       np;
    {hd, ho, md, mo, sd, so} = t;
    np = p;
    if (so != 4'd9) begin
      so = so + 4'd1;
    end else begin
      so = 4'd0;
      if (sd != 4'd5) begin
        sd = sd + 4'd1;
      end else begin
        sd = 4'd0;
        if (mo != 4'd9) begin
          mo = mo + 4'd1;
        end else begin
          mo = 4'd0;
          if (md != 4'd5) begin
            md = md + 4'd1;
          end else begin
            md = 4'd0;
            if (IS_24) begin
              if ((hd == 4'd2) && (ho == 4'd3)) begin
                hd = 4'd0;
                ho = 4'd0;
              end else if (ho == 4'd9) begin
                ho = 4'd0;
                hd = hd + 4'd1;
              end else begin
                ho = ho + 4'd1;
              end
            end else begin
              // 11 -> 12 flips am/pm; 12 -> 01 keeps it.
              if ((hd == 4'd1) && (ho == 4'd1)) begin
                ho = 4'd2;
                np = ~np;
              end else if ((hd == 4'd1) && (ho == 4'd2)) begin
                hd = 4'd0;
                ho = 4'd1;
              end else if (ho == 4'd9) begin
                ho = 4'd0;
                hd = 4'd1;
              end else begin
                ho = ho + 4'd1;
              end
            end
          end
        end
      end
    end
    return {np, hd, ho, md, mo, sd, so};
  endfunction

  // Digit at scan position idx; position 0 is the least-significant shown digit.
  function automatic logic [3:0] pick(input logic [23:0] t, input logic [IW-1:0] idx);
    logic [2:0] pos;
    logic [3:0] val;
    pos = 3'(idx) + DIG_OFS;
    case (pos)
      3'd0:    val = t[3:0];
      3'd1:    val = t[7:4];
      3'd2:    val = t[11:8];
      3'd3:    val = t[15:12];
      3'd4:    val = t[19:16];
      3'd5:    val = t[23:20];
      default: val = 4'd0;
    endcase
    return val;
  endfunction

  logic [23:0]           time_q, time_d;
  logic                  pm_q, pm_d;
  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]         scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  sec_tick_q, sec_tick_d;
  logic                  ld_err_q, ld_err_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]            digit_q, digit_d;
  logic                  tick_s;
  logic [24:0]           nxt_s;
  logic [NUM_DIGITS-1:0] onehot_s;
`ifdef WATCH_ALARM_EN
  logic [15:0]           al_q, al_d;
  logic                  al_pm_q, al_pm_d;
  logic                  alarm_q, alarm_d;
`endif

  // Next-state logic: prescalers, load/tick arbitration, alarm and scan outputs.
  always_comb begin
    time_d     = time_q;
    pm_d       = pm_q;
    tick_cnt_d = tick_cnt_q;
    scan_cnt_d = scan_cnt_q;
    idx_d      = idx_q;
    sec_tick_d = 1'b0;
    ld_err_d   = 1'b0;
    tick_s     = 1'b0;
    nxt_s      = advance(time_q, pm_q);
`ifdef WATCH_ALARM_EN
    al_d       = al_q;
    al_pm_d    = al_pm_q;
    alarm_d    = 1'b0;
`endif

    if (run) begin
      if (tick_cnt_q == TICK_LAST) begin
        tick_cnt_d = {TW{1'b0}};
        tick_s     = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + TW'(1);
      end
    end else begin
      tick_cnt_d = tick_cnt_q;
    end

    // Any load request wins over a coincident tick, even one that is rejected.
    if (load) begin
      if (time_ok(ld_time)) begin
        time_d     = ld_time;
        pm_d       = IS_24 ? 1'b0 : ld_pm;
        tick_cnt_d = {TW{1'b0}};
      end else begin
        ld_err_d = 1'b1;
      end
    end else if (tick_s) begin
      time_d     = nxt_s[23:0];
      pm_d       = nxt_s[24];
      sec_tick_d = 1'b1;
`ifdef WATCH_ALARM_EN
      if ((nxt_s[23:8] == al_q) && (nxt_s[7:0] == 8'h00) &&
          (IS_24 || (nxt_s[24] == al_pm_q))) begin
        alarm_d = 1'b1;
      end else begin
        alarm_d = 1'b0;
      end
`endif
    end else begin
      time_d = time_q;
    end

`ifdef WATCH_ALARM_EN
    if (al_set) begin
      if (hour_ok(al_time[15:12], al_time[11:8]) && sixty_ok(al_time[7:4], al_time[3:0])) begin
        al_d    = al_time;
        al_pm_d = IS_24 ? 1'b0 : al_pm;
      end else begin
        ld_err_d = 1'b1;
      end
    end else begin
      al_d = al_q;
    end
`endif

    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = {SW{1'b0}};
      if (idx_q == IDX_LAST) begin
        idx_d = {IW{1'b0}};
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      scan_cnt_d = scan_cnt_q + SW'(1);
    end

    onehot_s = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
    an_d     = ~onehot_s;
    digit_d  = pick(time_q, idx_q);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      time_q     <= TIME_RST;
      pm_q       <= 1'b0;
      tick_cnt_q <= {TW{1'b0}};
      scan_cnt_q <= {SW{1'b0}};
      idx_q      <= {IW{1'b0}};
      sec_tick_q <= 1'b0;
      ld_err_q   <= 1'b0;
      an_q       <= {NUM_DIGITS{1'b1}};
      digit_q    <= 4'd0;
`ifdef WATCH_ALARM_EN
      al_q       <= IS_24 ? 16'h0000 : 16'h1200;
      al_pm_q    <= 1'b0;
      alarm_q    <= 1'b0;
`endif
    end else begin
      time_q     <= time_d;
      pm_q       <= pm_d;
      tick_cnt_q <= tick_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      sec_tick_q <= sec_tick_d;
      ld_err_q   <= ld_err_d;
      an_q       <= an_d;
      digit_q    <= digit_d;
`ifdef WATCH_ALARM_EN
      al_q       <= al_d;
      al_pm_q    <= al_pm_d;
      alarm_q    <= alarm_d;
`endif
    end
  end

  assign time_bcd = time_q;
  assign pm       = pm_q;
  assign sec_tick = sec_tick_q;
  assign ld_err   = ld_err_q;
  assign an       = an_q;
  assign digit    = digit_q;
`ifdef WATCH_ALARM_EN
  assign alarm    = alarm_q;
`endif

endmodule

// File: tb/tb_watch_bcd_scan.sv
// Bench for watch_bcd_scan: instance a (24h, 6 digits) and instance b (12h, 4 digits)
// share one stimulus stream. The reference model keeps time as seconds since
// midnight and derives BCD/pm/scan outputs arithmetically.
module tb_watch_bcd_scan;

  localparam int TD_A = 4;
  localparam int SD_A = 2;
  localparam int TD_B = 5;
  localparam int SD_B = 3;

  logic        clk = 1'b0;
  logic        rst, run, load, ld_pm;
  logic [23:0] ld_time;
  logic [23:0] o_time[2];
  logic        o_pm[2], o_tick[2], o_err[2];
  logic [3:0]  o_digit[2];
  logic [5:0]  an_a;
  logic [3:0]  an_b;
  logic [5:0]  o_an[2];
`ifdef WATCH_ALARM_EN
  logic        al_set, al_pm;
  logic [15:0] al_time;
  logic        o_alarm[2];
  int          al_t[2];
  bit          e_alarm[2];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  watch_bcd_scan #(.TICK_DIV(TD_A), .SCAN_DIV(SD_A), .H24(1), .NUM_DIGITS(6)) dut_a (
    .clk(clk), .rst(rst), .run(run), .load(load), .ld_time(ld_time), .ld_pm(ld_pm),
`ifdef WATCH_ALARM_EN
    .al_set(al_set), .al_time(al_time), .al_pm(al_pm), .alarm(o_alarm[0]),
`endif
    .time_bcd(o_time[0]), .pm(o_pm[0]), .sec_tick(o_tick[0]), .ld_err(o_err[0]),
    .digit(o_digit[0]), .an(an_a));

  watch_bcd_scan #(.TICK_DIV(TD_B), .SCAN_DIV(SD_B), .H24(0), .NUM_DIGITS(4)) dut_b (
    .clk(clk), .rst(rst), .run(run), .load(load), .ld_time(ld_time), .ld_pm(ld_pm),
`ifdef WATCH_ALARM_EN
    .al_set(al_set), .al_time(al_time), .al_pm(al_pm), .alarm(o_alarm[1]),
`endif
    .time_bcd(o_time[1]), .pm(o_pm[1]), .sec_tick(o_tick[1]), .ld_err(o_err[1]),
    .digit(o_digit[1]), .an(an_b));

  assign o_an[0] = an_a;
  assign o_an[1] = {2'b00, an_b};

  // ---------------- reference model ----------------
  function automatic logic [24:0] to_bcd(input int t, input bit h24);
    int h, m, s;
    logic p;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    p = 1'b0;
    if (!h24) begin
      p = (h >= 12);
      h = h % 12;
      if (h == 0) h = 12;
    end
    return {p, 4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic bit hm_valid(input logic [3:0] hd, input logic [3:0] ho, input bit h24);
    int h;
    if (hd > 4'd9 || ho > 4'd9) return 1'b0;
    h = int'(hd) * 10 + int'(ho);
    return h24 ? (h <= 23) : (h >= 1 && h <= 12);
  endfunction

  function automatic bit time_valid(input logic [23:0] t, input bit h24);
    return hm_valid(t[23:20], t[19:16], h24) && t[15:12] <= 4'd5 && t[11:8] <= 4'd9 &&
           t[7:4] <= 4'd5 && t[3:0] <= 4'd9;
  endfunction

  function automatic int to_sec(input logic [23:0] t, input logic p, input bit h24);
    int h;
    h = int'(t[23:20]) * 10 + int'(t[19:16]);
    if (!h24) h = (h % 12) + (p ? 12 : 0);
    return h * 3600 + (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 +
           int'(t[7:4]) * 10 + int'(t[3:0]);
  endfunction

  int         m_t[2], m_pre[2], m_k[2];
  bit         e_tick[2], e_err[2];
  logic [5:0] e_an[2];
  logic [3:0] e_digit[2];
  bit         started = 1'b0;

  // Model update on every rising edge, from the inputs presented at that edge.
  always @(posedge clk) begin : mdl
    int k, idx, npre, nt, nd, sdv, tdv;
    logic [24:0] cur;
    logic [23:0] cv;
    logic [5:0]  mask;
    bit tk, err, st, alm, h24;
    started <= 1'b1;
    for (int d = 0; d < 2; d++) begin
      h24  = (d == 0);
      nd   = h24 ? 6 : 4;
      sdv  = h24 ? SD_A : SD_B;
      tdv  = h24 ? TD_A : TD_B;
      mask = h24 ? 6'h3F : 6'h0F;
      if (rst) begin
        m_t[d] <= 0; m_pre[d] <= 0; m_k[d] <= 0;
        e_tick[d] <= 1'b0; e_err[d] <= 1'b0; e_an[d] <= mask; e_digit[d] <= 4'd0;
`ifdef WATCH_ALARM_EN
        al_t[d] <= 0; e_alarm[d] <= 1'b0;
`endif
      end else begin
        k   = m_k[d] + 1;
        idx = ((k - 1) / sdv) % nd;
        cur = to_bcd(m_t[d], h24);
        cv  = cur[23:0];
        e_digit[d] <= cv[(idx + ((nd == 4) ? 2 : 0)) * 4 +: 4];
        e_an[d]    <= ~(6'd1 << idx) & mask;
        tk   = run && (m_pre[d] == tdv - 1);
        npre = run ? (tk ? 0 : m_pre[d] + 1) : m_pre[d];
        nt = m_t[d]; err = 1'b0; st = 1'b0; alm = 1'b0;
        if (load) begin
          if (time_valid(ld_time, h24)) begin
            nt = to_sec(ld_time, ld_pm, h24);
            npre = 0;
          end else begin
            err = 1'b1;
          end
        end else if (tk) begin
          nt = (m_t[d] + 1) % 86400;
          st = 1'b1;
`ifdef WATCH_ALARM_EN
          alm = (nt == al_t[d]);
`endif
        end
`ifdef WATCH_ALARM_EN
        if (al_set) begin
          if (hm_valid(al_time[15:12], al_time[11:8], h24) && al_time[7:4] <= 4'd5 &&
              al_time[3:0] <= 4'd9)
            al_t[d] <= to_sec({al_time, 8'h00}, al_pm, h24);
          else
            err = 1'b1;
        end
        e_alarm[d] <= alm;
`endif
        m_k[d] <= k; m_t[d] <= nt; m_pre[d] <= npre;
        e_tick[d] <= st; e_err[d] <= err;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [24:0] ex;
    string nm;
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        nm = (d == 0) ? "a" : "b";
        ex = to_bcd(m_t[d], d == 0);
        chk({nm, ".time"},  32'(o_time[d]),  32'(ex[23:0]));
        chk({nm, ".pm"},    32'(o_pm[d]),    32'(ex[24]));
        chk({nm, ".tick"},  32'(o_tick[d]),  32'(e_tick[d]));
        chk({nm, ".err"},   32'(o_err[d]),   32'(e_err[d]));
        chk({nm, ".an"},    32'(o_an[d]),    32'(e_an[d]));
        chk({nm, ".digit"}, 32'(o_digit[d]), 32'(e_digit[d]));
`ifdef WATCH_ALARM_EN
        chk({nm, ".alarm"}, 32'(o_alarm[d]), 32'(e_alarm[d]));
`endif
      end
    end
  end

  // Wait (bounded) until instance d shows sec_tick.
  task automatic wait_tick(input int d, input int limit);
    int n = 0;
    while (n < limit && o_tick[d] !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    chk("wait_tick", 32'(n < limit), 32'd1);
  endtask

  task automatic do_load(input logic [23:0] t, input logic p);
    ld_time = t; ld_pm = p; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  logic [5:0] sc_an[7]  = '{6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111,
                            6'b111110, 6'b111101};
  logic [3:0] sc_dig[7] = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd6, 4'd5};

  initial begin
    logic [5:0] prev;
    bit found;
    rst = 1'b1; run = 1'b0; load = 1'b0; ld_time = 24'h0; ld_pm = 1'b0;
`ifdef WATCH_ALARM_EN
    al_set = 1'b0; al_time = 16'h0; al_pm = 1'b0;
`endif
    // Reset values.
    @(negedge clk);
    chk("rst.an_a", 32'(an_a), 32'h3F);
    chk("rst.an_b", 32'(an_b), 32'hF);
    chk("rst.time_a", 32'(o_time[0]), 32'h000000);
    chk("rst.time_b", 32'(o_time[1]), 32'h120000);
    chk("rst.pm_b", 32'(o_pm[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0; run = 1'b1;
    // First second after four running cycles.
    repeat (4) @(negedge clk);
    chk("first.tick_a", 32'(o_tick[0]), 32'd1);
    chk("first.time_a", 32'(o_time[0]), 32'h000001);
    chk("first.an_a", 32'(an_a), 32'(6'b111101));
    // 24h wrap; the same load is illegal for 12h and coincides with b's first tick.
    do_load(24'h235959, 1'b0);
    chk("ld.time_a", 32'(o_time[0]), 32'h235959);
    chk("ld.err_b", 32'(o_err[1]), 32'd1);
    chk("ld.time_b", 32'(o_time[1]), 32'h120000);
    chk("ld.tick_b", 32'(o_tick[1]), 32'd0);
    wait_tick(0, 10);
    chk("wrap.time_a", 32'(o_time[0]), 32'h000000);
    // Load coincident with a tick: loaded value, no sec_tick.
    repeat (3) @(negedge clk);
    do_load(24'h101010, 1'b0);
    chk("coinc.time_a", 32'(o_time[0]), 32'h101010);
    chk("coinc.tick_a", 32'(o_tick[0]), 32'd0);
    // 12h transitions.
    do_load(24'h115959, 1'b0);
    wait_tick(1, 12);
    chk("h12.time_b", 32'(o_time[1]), 32'h120000);
    chk("h12.pm_b", 32'(o_pm[1]), 32'd1);
    do_load(24'h125959, 1'b1);
    wait_tick(1, 12);
    run = 1'b0;
    chk("h01.time_b", 32'(o_time[1]), 32'h010000);
    chk("h01.pm_b", 32'(o_pm[1]), 32'd1);
    chk("h13.time_a", 32'(o_time[0]), 32'h130000);
    // Rejected loads.
    do_load(24'h240000, 1'b0);
    chk("bad24.err_a", 32'(o_err[0]), 32'd1);
    chk("bad24.time_a", 32'(o_time[0]), 32'h130000);
    @(negedge clk);
    chk("bad24.err_a_gone", 32'(o_err[0]), 32'd0);
    do_load(24'h00000A, 1'b0);
    chk("badso.err_a", 32'(o_err[0]), 32'd1);
    chk("badso.time_b", 32'(o_time[1]), 32'h010000);
    do_load(24'h000000, 1'b0);
    chk("h00.err_b", 32'(o_err[1]), 32'd1);
    chk("h00.err_a", 32'(o_err[0]), 32'd0);
    // Scan order on the 6-digit instance.
    do_load(24'h123456, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      prev = an_a;
      @(negedge clk);
      found = (an_a == 6'b111101) && (prev != 6'b111101);
    end
    chk("scan.sync", 32'(found), 32'd1);
    for (int s = 0; s < 7; s++) begin
      chk("scan.an", 32'(an_a), 32'(sc_an[s]));
      chk("scan.digit", 32'(o_digit[0]), 32'(sc_dig[s]));
      repeat (2) @(negedge clk);
    end
`ifdef WATCH_ALARM_EN
    begin
      int na = 0;
      logic [23:0] at = 24'h0;
      al_time = 16'h0730; al_pm = 1'b0; al_set = 1'b1;
      @(negedge clk);
      al_set = 1'b0;
      chk("al.err_a", 32'(o_err[0]), 32'd0);
      run = 1'b1;
      do_load(24'h072958, 1'b0);
      for (int i = 0; i < 20; i++) begin
        if (o_alarm[0] === 1'b1) begin na++; at = o_time[0]; end
        @(negedge clk);
      end
      chk("al.count_a", 32'(na), 32'd1);
      chk("al.time_a", 32'(at), 32'h073000);
      al_time = 16'h0760; al_set = 1'b1;
      @(negedge clk);
      al_set = 1'b0;
      chk("al.bad_err", 32'(o_err[0]), 32'd1);
    end
`endif
    // Reset in the middle of counting.
    run = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid.time_a", 32'(o_time[0]), 32'h000000);
    chk("mid.time_b", 32'(o_time[1]), 32'h120000);
    chk("mid.an_a", 32'(an_a), 32'h3F);
    rst = 1'b0;
`ifdef WATCH_ALARM_EN
    do_load(24'h235959, 1'b0);
    wait_tick(0, 10);
    chk("mid.alarm_a", 32'(o_alarm[0]), 32'd1);
`endif
    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
